// File: rtl/arm_regfile_sb.sv
// arm_regfile_sb: LEGv8 register file with N read ports, write-through bypass, XZR and pending-write scoreboard.
// Optional feature macro: RF_STALL_CNT_EN adds a saturating STALL_CNT output counting stalled cycles.
module arm_regfile_sb #(
  parameter int DATA_W   = 64,
  parameter int NUM_RD   = 2,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [5*NUM_RD-1:0]      RD_ADDR,
  input  logic [NUM_RD-1:0]        RD_USE,
  output logic [DATA_W*NUM_RD-1:0] RD_DATA,
  input  logic                     WR_EN,
  input  logic [4:0]               WR_ADDR,
  input  logic [DATA_W-1:0]        WR_DATA,
  input  logic                     ISSUE_EN,
  input  logic [4:0]               ISSUE_RD,
  input  logic                     FLUSH,
  output logic [NUM_RD-1:0]        RD_BUSY,
  output logic                     STALL,
`ifdef RF_STALL_CNT_EN
  output logic [31:0]              STALL_CNT,
`endif
  output logic [5:0]               PEND_CNT
);
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [31:0]         pend_w;
  logic                wr_ok;
  assign wr_ok  = WR_EN && WR_ADDR != 5'(ZERO_REG) && 32'(WR_ADDR) < 32'(NUM_REGS);
  assign pend_w = 32'(pend_q);
  // Scoreboard next state: flush clears, a new issue beats a same-cycle writeback.
  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NUM_REGS; r++)
      pend_d[r] = FLUSH ? 1'b0 :
                  (ISSUE_EN && ISSUE_RD == 5'(r) && r != ZERO_REG) ? 1'b1 :
                  (WR_EN && WR_ADDR == 5'(r)) ? 1'b0 : pend_q[r];
  end
  // Architectural state and scoreboard; XZR writes are dropped.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      pend_q <= '0;
    end else begin
      if (wr_ok) regs_q[WR_ADDR] <= WR_DATA;
      pend_q <= pend_d;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [4:0] a;
    logic       zero, hit;
    assign a    = RD_ADDR[5*i +: 5];
    assign zero = a == 5'(ZERO_REG);
    assign hit  = WR_EN && WR_ADDR == a;
    assign RD_DATA[DATA_W*i +: DATA_W] = zero ? '0 : hit ? WR_DATA :
                                         (32'(a) < 32'(NUM_REGS)) ? regs_q[a] : '0;
    assign RD_BUSY[i] = pend_w[a] && !hit && !zero;
  end
  assign STALL = |(RD_BUSY & RD_USE);
  // Population count of pending bits.
  always_comb begin
    PEND_CNT = '0;
    for (int r = 0; r < NUM_REGS; r++) PEND_CNT = PEND_CNT + 6'(pend_q[r]);
  end
`ifdef RF_STALL_CNT_EN
  // Saturating stalled-cycle counter, cleared by flush.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) STALL_CNT <= '0;
    else if (FLUSH) STALL_CNT <= '0;
    else if (STALL && STALL_CNT != 32'hFFFF_FFFF) STALL_CNT <= STALL_CNT + 32'd1;
  end
`endif
endmodule
